instruction_fetch: RTL

Pipeline stage 1 of the baseline ALU pipeline. Holds the program counter and fetches from the instruction cache. Pre-decodes each fetched word for JAL and conditional branches, and predicts with a 2-bit saturating counter FSM. Drives the IF/ID register consumed by instruction decode (`instruction_1`, `PC_1`, `prev_taken_1`) and responds to that stage's hazard, flush and stall signals.

---
 rtl/instruction_fetch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, icache request, JAL/branch pre-decode, 2-bit predictor, IF/ID register
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   memory_stall                 freezes PC, IF/ID and predictor
//   PC_write                     load-use hold of PC and IF/ID
//   flush, branch_target         redirect from EX
//   update_valid, update_taken   resolved conditional-branch outcome from EX
//   I_ren, I_addr                icache request (word address)
//   I_rdata, I_stall             icache response, same cycle
//   instruction_1, PC_1, prev_taken_1   IF/ID register
//
// Build option: BRANCH_PREDICT_EN enables the global 2-bit predictor for
// conditional branches; without it they are predicted not-taken.

module instruction_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memory_stall,
  input  logic        PC_write,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic        update_valid,
  input  logic        update_taken,
  output logic        I_ren,
  output logic [29:0] I_addr,
  input  logic [31:0] I_rdata,
  input  logic        I_stall,
  output logic [31:0] instruction_1,
  output logic [31:0] PC_1,
  output logic        prev_taken_1
);

  localparam logic [31:0] NOP = 32'h00000013;

  // PC kept as a word pointer so PC[1:0] is zero by construction.
  logic [29:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc1_q, pc1_d;
  logic        taken1_q, taken1_d;

  logic [31:0] pc;
  logic [6:0]  op;
  logic        is_jal, is_br, br_pred_taken, taken;
  logic [31:0] imm_j, imm_b, target, pred_next;

  assign pc     = {pc_q, 2'b00};
  assign I_addr = pc_q;
  assign I_ren  = rst_n;

  // Pre-decode
  assign op     = I_rdata[6:0];
  assign is_jal = (op[6:5] == 2'b11) && (op[3:2] == 2'b11);
  assign is_br  = (op[6:5] == 2'b11) && (op[3:2] == 2'b00);
  assign imm_j  = {{11{I_rdata[31]}}, I_rdata[31], I_rdata[19:12], I_rdata[20],
                   I_rdata[30:21], 1'b0};
  assign imm_b  = {{19{I_rdata[31]}}, I_rdata[31], I_rdata[7], I_rdata[30:25],
                   I_rdata[11:8], 1'b0};
  assign target    = pc + (is_jal ? imm_j : imm_b);
  assign taken     = is_jal | (is_br & br_pred_taken);
  assign pred_next = taken ? target : (pc + 32'd4);

`ifdef BRANCH_PREDICT_EN
  typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} pred_e;
  pred_e pred_q, pred_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pred_q <= WNT;
    else        pred_q <= pred_d;
  end

  always_comb begin
    pred_d = pred_q;
    if (!memory_stall && update_valid) begin
      case (pred_q)
        SNT:     pred_d = update_taken ? WNT : SNT;
        WNT:     pred_d = update_taken ? WT  : SNT;
        WT:      pred_d = update_taken ? ST  : WNT;
        default: pred_d = update_taken ? ST  : WT;
      endcase
    end
  end

  // Lookup reads the registered state, so a same-cycle update is not seen.
  assign br_pred_taken = (pred_q == WT) || (pred_q == ST);

  logic unused_bits;
  assign unused_bits = ^{pred_next[1:0], branch_target[1:0]};
`else
  assign br_pred_taken = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{pred_next[1:0], branch_target[1:0], update_valid, update_taken};
`endif

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc1_d    = pc1_q;
    taken1_d = taken1_q;
    if (memory_stall) begin
      // hold everything; EX re-presents any flush
    end else if (flush) begin
      pc_d     = branch_target[31:2];
      instr_d  = NOP;
      pc1_d    = 32'd0;
      taken1_d = 1'b0;
    end else if (PC_write) begin
      // hold so decode re-sees the same instruction
    end else if (I_stall) begin
      instr_d  = NOP;
      pc1_d    = 32'd0;
      taken1_d = 1'b0;
    end else begin
      pc_d     = pred_next[31:2];
      instr_d  = I_rdata;
      pc1_d    = pc;
      taken1_d = taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= 30'd0;
      instr_q  <= NOP;
      pc1_q    <= 32'd0;
      taken1_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc1_q    <= pc1_d;
      taken1_q <= taken1_d;
    end
  end

  assign instruction_1 = instr_q;
  assign PC_1          = pc1_q;
  assign prev_taken_1  = taken1_q;

endmodule
